// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// producers. It grants a pending requester and latches its byte. It then
// drives the transmitter enable until busy rises and follows busy through
// the frame. When the frame completes it pulses that requester's ack.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 64,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          tx_enable,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          active,
    output logic                          timeout_err
);

    localparam int IW   = $clog2(NUM_REQ);
    localparam int MAXC = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t                            state, state_d;
    logic [CW-1:0]                     cnt, cnt_d, cnt_inc;
    logic [IW-1:0]                     rr_ptr, rr_d;
    logic [IW-1:0]                     gid_d, sel;
    logic                              en_d, to_d, found;
    logic [DATA_WIDTH-1:0]             data_d;
    logic [NUM_REQ-1:0]                ack_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_bytes;
    int                                j;

    assign req_bytes = req_data;
    // Saturating increment so a long stall can never wrap the counter.
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;

    // Round-robin scan: first pending requester after the last one served.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid[IW'(j)]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rr_d    = rr_ptr;
        en_d    = tx_enable;
        data_d  = tx_data;
        gid_d   = grant_id;
        ack_d   = '0;
        to_d    = 1'b0;
        case (state)
            IDLE: begin
                en_d = 1'b0;
                // A stale frame still on the line blocks any new grant.
                if (found && !tx_busy) begin
                    data_d  = req_bytes[sel];
                    gid_d   = sel;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                en_d  = 1'b1;
                cnt_d = cnt_inc;
                if (tx_busy) begin
                    en_d    = 1'b0;
                    state_d = WAIT_DONE;
                end else if (cnt == TO_LAST) begin
                    // Transmitter never started: give up and pass the turn on.
                    en_d    = 1'b0;
                    to_d    = 1'b1;
                    rr_d    = grant_id;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                en_d = 1'b0;
                if (!tx_busy) begin
                    ack_d[grant_id] = 1'b1;
                    rr_d            = grant_id;
                    cnt_d           = '0;
                    state_d         = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                en_d  = 1'b0;
                cnt_d = cnt_inc;
                if (cnt == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= IW'(NUM_REQ - 1);
            tx_enable   <= 1'b0;
            tx_data     <= '1;
            grant_id    <= '0;
            req_ack     <= '0;
            timeout_err <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            rr_ptr      <= rr_d;
            tx_enable   <= en_d;
            tx_data     <= data_d;
            grant_id    <= gid_d;
            req_ack     <= ack_d;
            timeout_err <= to_d;
            active      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter, grant scoreboard,
// table of request patterns plus hand sequences for timeout, reset and drop.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int TO  = 64;
    localparam int GAP = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0][DW-1:0]  req_d;
    logic [NR-1:0]          req_ack;
    logic                   tx_enable;
    logic [DW-1:0]          tx_data;
    logic                   tx_busy = 1'b0;
    logic [1:0]             grant_id;
    logic                   active;
    logic                   timeout_err;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .START_TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_d),
        .req_ack(req_ack), .tx_enable(tx_enable), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {int id; logic [7:0] data;} exp_t;
    typedef struct {logic [3:0] mask; logic [7:0] base; int n; logic [5:0][1:0] ids;} vec_t;

    exp_t  exp_q[$];
    int    ack_q[$];
    exp_t  e;
    vec_t  vecs[6];
    int    errors = 0, checks = 0;
    int    cyc = 0, grant_cyc = 0, ack_total = 0, cur_id = 0;
    int    frame_len = 20, bcnt = 0;
    logic  tx_live = 1'b1, sb_on = 1'b1, en_q = 1'b0;
    logic [7:0] last_ack_data = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [5:0][1:0] seq(input int a, b, c, d, f, g);
        seq = {2'(g), 2'(f), 2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: on enable, busy rises next edge and stays for frame_len cycles.
    always @(posedge clk) begin
        if (!tx_busy) begin
            if (tx_enable && tx_live) begin
                tx_busy <= 1'b1;
                bcnt    <= frame_len - 1;
            end
        end else if (bcnt == 0) begin
            tx_busy <= 1'b0;
        end else begin
            bcnt <= bcnt - 1;
        end
    end

    // Monitor: grants popped from the scoreboard, acks checked against the grant.
    always @(negedge clk) begin
        if (tx_enable && !en_q) begin
            grant_cyc = cyc;
            if (sb_on) begin
                if (exp_q.size() == 0) chk("grant_expected", 0, 1);
                else begin
                    e      = exp_q.pop_front();
                    cur_id = e.id;
                    chk("grant_id", 32'(grant_id), e.id);
                    chk("grant_data", 32'(tx_data), 32'(e.data));
                end
            end
        end
        en_q = tx_enable;
        if (req_ack != '0) begin
            chk("ack_onehot", 32'(req_ack), 32'(4'b1 << cur_id));
            // grant edge -> busy seen (2) -> frame_len busy cycles -> ack
            chk("ack_latency", cyc - grant_cyc, frame_len + 2);
            chk("ack_no_timeout", 32'(timeout_err), 0);
            ack_total++;
            ack_q.push_back(cyc);
            last_ack_data = tx_data;
        end
        if (timeout_err) chk("timeout_no_ack", 32'(req_ack), 0);
    end

    task automatic do_reset();
        int k;
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        k = 0;
        while (tx_busy && k < 300) begin @(negedge clk); k++; end
        reset = 1'b0;
        exp_q.delete();
        tx_live = 1'b1;
        sb_on   = 1'b1;
    endtask

    task automatic wait_acks(input int target, input int budget, input string nm);
        int k = 0;
        while (ack_total < target && k < budget) begin @(negedge clk); k++; end
        chk(nm, 32'(ack_total >= target), 1);
    endtask

    task automatic wait_busy(input int budget, input string nm);
        int k = 0;
        while (!tx_busy && k < budget) begin @(negedge clk); k++; end
        chk(nm, 32'(tx_busy), 1);
    endtask

    initial begin
        int a0, k, t0;
        reset     = 1'b1;
        req_valid = '0;
        req_d     = '0;

        vecs[0] = '{4'b0001, 8'hA3, 2, seq(0, 0, 0, 0, 0, 0)};
        vecs[1] = '{4'b1111, 8'h10, 5, seq(0, 1, 2, 3, 0, 0)};
        vecs[2] = '{4'b1010, 8'h10, 4, seq(1, 3, 1, 3, 0, 0)};
        vecs[3] = '{4'b0100, 8'h20, 1, seq(2, 0, 0, 0, 0, 0)};
        vecs[4] = '{4'b1001, 8'h30, 3, seq(0, 3, 0, 0, 0, 0)};
        vecs[5] = '{4'b0110, 8'h40, 3, seq(1, 2, 1, 0, 0, 0)};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_enable", 32'(tx_enable), 0);
        chk("rst_tx_data", 32'(tx_data), 32'hFF);
        chk("rst_req_ack", 32'(req_ack), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_req_enable", 32'(tx_enable), 0);

        // Single requester, long frame
        frame_len = 100;
        req_d[0]  = 8'hA3;
        exp_q.push_back('{id: 0, data: 8'hA3});
        a0 = ack_total;
        @(negedge clk) req_valid = 4'b0001;
        @(posedge clk); #1;
        chk("t1_enable_next_cycle", 32'(tx_enable), 1);
        chk("t1_active", 32'(active), 1);
        k = 0;
        while (!tx_busy && k < 10) begin @(posedge clk); #1; k++; end
        chk("t1_enable_held_until_busy", 32'(tx_enable), 1);
        @(posedge clk); #1;
        chk("t1_enable_drop", 32'(tx_enable), 0);
        wait_acks(a0 + 1, 200, "t1_ack_seen");
        req_valid = '0;
        repeat (10) @(negedge clk);
        chk("t1_ack_count", ack_total - a0, 1);

        // Table of request patterns; requesters stay valid until n acks
        for (int v = 0; v < 6; v++) begin
            do_reset();
            frame_len = 20;
            ack_q.delete();
            for (int i = 0; i < NR; i++) req_d[i] = 8'(vecs[v].base + 8'(i));
            for (int n = 0; n < vecs[v].n; n++)
                exp_q.push_back('{id: int'(vecs[v].ids[n]), data: 8'(vecs[v].base + 8'(vecs[v].ids[n]))});
            a0 = ack_total;
            @(negedge clk) req_valid = vecs[v].mask;
            wait_acks(a0 + vecs[v].n, vecs[v].n * 40 + 20, "vec_acks_seen");
            req_valid = '0;
            repeat (10) @(negedge clk);
            chk("vec_ack_count", ack_total - a0, vecs[v].n);
            chk("vec_grants_left", exp_q.size(), 0);
            // grant->ack is frame+2, ack->next grant is GAP+1
            for (int n = 1; n < ack_q.size(); n++)
                chk("vec_ack_spacing", ack_q[n] - ack_q[n-1], frame_len + GAP + 3);
        end

        // Start timeout: transmitter never raises busy
        do_reset();
        tx_live  = 1'b0;
        sb_on    = 1'b0;
        req_d[1] = 8'h77;
        a0 = ack_total;
        @(negedge clk) req_valid = 4'b0010;
        k = 0;
        while (!tx_enable && k < 5) begin @(negedge clk); k++; end
        chk("to_grant", 32'(tx_enable), 1);
        t0 = cyc;
        k = 0;
        while (!timeout_err && k < 100) begin @(negedge clk); k++; end
        chk("to_pulse_seen", 32'(timeout_err), 1);
        chk("to_delay", cyc - t0, TO);
        chk("to_enable_low", 32'(tx_enable), 0);
        chk("to_active_low", 32'(active), 0);
        @(posedge clk); #1;
        chk("to_pulse_width", 32'(timeout_err), 0);
        chk("to_regrant_en", 32'(tx_enable), 1);
        chk("to_regrant_id", 32'(grant_id), 1);
        chk("to_no_ack", ack_total - a0, 0);

        // Reset 20 cycles into WAIT_DONE
        do_reset();
        frame_len = 100;
        req_d[2]  = 8'h5A;
        req_d[0]  = 8'hC0;
        exp_q.push_back('{id: 2, data: 8'h5A});
        a0 = ack_total;
        @(negedge clk) req_valid = 4'b0100;
        wait_busy(10, "rst_mid_busy_started");
        repeat (20) @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'b0101;
        exp_q.push_back('{id: 0, data: 8'hC0});
        exp_q.push_back('{id: 2, data: 8'h5A});
        @(posedge clk); #1;
        chk("rst_mid_enable", 32'(tx_enable), 0);
        chk("rst_mid_active", 32'(active), 0);
        chk("rst_mid_grant_id", 32'(grant_id), 0);
        chk("rst_mid_ack", 32'(req_ack), 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("stale_busy_blocks_grant", 32'(tx_enable), 0);
        wait_acks(a0 + 2, 400, "rst_acks_seen");
        req_valid = '0;
        repeat (10) @(negedge clk);
        chk("rst_ack_count", ack_total - a0, 2);
        chk("rst_grants_left", exp_q.size(), 0);

        // Request dropped and data changed mid-frame
        do_reset();
        frame_len = 30;
        req_d[2]  = 8'h55;
        exp_q.push_back('{id: 2, data: 8'h55});
        a0 = ack_total;
        @(negedge clk) req_valid = 4'b0100;
        wait_busy(10, "drop_busy_started");
        @(negedge clk);
        req_valid = '0;
        req_d[2]  = 8'hAA;
        wait_acks(a0 + 1, 100, "drop_ack_seen");
        repeat (10) @(negedge clk);
        chk("drop_ack_count", ack_total - a0, 1);
        chk("drop_tx_data", 32'(last_ack_data), 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish by %0d cycles", cyc);
        $fatal(1);
    end

endmodule
